// File: rtl/prll_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// prll_bus_rr_arbiter
//
// Round-robin arbiter and sequencer for a shared parallel bus fed by DRVRS
// show-ahead driver FIFOs. Each message takes three cycles:
//   ARB  : pick the first pending driver at or after rr_ptr (wrapping)
//   POP  : pop that driver's head word into the hold register
//   PUSH : present the held word on D_push and strobe the addressed terminals
//
// Word layout: [BITS-1 -: 8] target, [BITS-9 -: 8] source, rest payload.
// A target equal to BROADCAST goes to every terminal except the source.
// Self-addressed words and unknown targets are dropped (push stays 0).
//
// Optional build macro: PRLL_ARB_DROP_CNT_EN
//   When defined, adds a 16-bit saturating drop_cnt output that counts PUSH
//   cycles in which no terminal was strobed.
// -----------------------------------------------------------------------------
module prll_bus_rr_arbiter #(
    parameter int         DRVRS     = 2,
    parameter int         BITS      = 32,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DRVRS-1:0]         pndng,
    input  logic [DRVRS*BITS-1:0]    D_pop,
    output logic [DRVRS-1:0]         pop,
    output logic [DRVRS-1:0]         push,
    output logic [BITS-1:0]          D_push,
    output logic                     busy,
    output logic [$clog2(DRVRS)-1:0] gnt_idx
`ifdef PRLL_ARB_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int IW = $clog2(DRVRS);

    typedef logic [IW-1:0] idx_t;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e          state_q, state_d;
    idx_t            rr_ptr_q, rr_ptr_d;
    idx_t            gnt_idx_q, gnt_idx_d;
    logic [BITS-1:0] hold_q, hold_d;

    // -------------------------------------------------------------------------
    // Arbitration helpers
    // -------------------------------------------------------------------------
    logic [DRVRS-1:0] hi_mask;     // drivers at or above rr_ptr
    logic [DRVRS-1:0] masked;      // pending drivers at or above rr_ptr
    idx_t             win_hi;      // lowest pending index >= rr_ptr
    idx_t             win_lo;      // lowest pending index overall (wrap case)
    idx_t             winner;
    logic             any_pndng;

    // Granted driver's head word and pending flag
    logic [BITS-1:0]  head_word;
    logic             head_pndng;
    idx_t             gnt_next;    // (gnt_idx + 1) mod DRVRS

    // Push decode of the held word
    logic [7:0]       hold_tgt;
    logic [7:0]       hold_src;
    logic [DRVRS-1:0] push_vec;

    // Round-robin winner: lowest pending index at or after rr_ptr, else wrap
    // NOTE: every signal written here gets a default first, so no latch is
    // inferred on any path through the block.
    always_comb begin
        hi_mask   = '0;
        win_hi    = '0;
        win_lo    = '0;
        for (int i = 0; i < DRVRS; i++) begin
            hi_mask[i] = (idx_t'(i) >= rr_ptr_q);
        end
        masked    = pndng & hi_mask;
        any_pndng = |pndng;
        // Descending scan so the lowest qualifying index is written last.
        for (int i = DRVRS - 1; i >= 0; i--) begin
            if (masked[i]) win_hi = idx_t'(i);
            if (pndng[i])  win_lo = idx_t'(i);
        end
        winner = (|masked) ? win_hi : win_lo;
    end

    // Select the granted driver's head word and pending flag
    always_comb begin
        head_word  = '0;
        head_pndng = 1'b0;
        for (int i = 0; i < DRVRS; i++) begin
            if (gnt_idx_q == idx_t'(i)) begin
                head_word  = D_pop[i*BITS +: BITS];
                head_pndng = pndng[i];
            end
        end
        gnt_next = (gnt_idx_q == idx_t'(DRVRS - 1)) ? '0 : gnt_idx_q + idx_t'(1);
    end

    // Decode the terminal strobe vector from the held word's target/source
    always_comb begin
        hold_tgt = hold_q[BITS-1 -: 8];
        hold_src = hold_q[BITS-9 -: 8];
        push_vec = '0;
        for (int i = 0; i < DRVRS; i++) begin
            if (hold_tgt == BROADCAST) begin
                // A source outside the terminal range matches nobody, so
                // every terminal receives the broadcast.
                push_vec[i] = (hold_src != 8'(i));
            end else begin
                // Unknown targets never match an index; self-addressed
                // words are suppressed by the source comparison.
                push_vec[i] = (hold_tgt == 8'(i)) && (hold_tgt != hold_src);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // -------------------------------------------------------------------------

    // State and datapath registers with synchronous active-high reset
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB;
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            hold_q    <= hold_d;
        end
    end

    // Next-state logic: ARB -> POP -> PUSH -> ARB, POP aborts if pndng drops
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB:     if (any_pndng) state_d = POP;
            POP:     state_d = head_pndng ? PUSH : ARB;
            PUSH:    state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Datapath next values: latch grant in ARB, capture word and advance pointer in POP
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        hold_d    = hold_q;
        if (state_q == ARB && any_pndng) begin
            gnt_idx_d = winner;
        end
        if (state_q == POP && head_pndng) begin
            hold_d   = head_word;
            rr_ptr_d = gnt_next;
        end
    end

    // Output logic; reset forces all strobes and the bus quiet in the same cycle
    always_comb begin
        pop    = '0;
        push   = '0;
        D_push = '0;
        busy   = 1'b0;
        if (!reset) begin
            // D_push follows hold, so it keeps the last word outside PUSH.
            D_push = hold_q;
            busy   = (state_q != ARB);
            if (state_q == POP && head_pndng) begin
                for (int i = 0; i < DRVRS; i++) begin
                    pop[i] = (gnt_idx_q == idx_t'(i));
                end
            end
            if (state_q == PUSH) begin
                push = push_vec;
            end
        end
    end

    assign gnt_idx = gnt_idx_q;

`ifdef PRLL_ARB_DROP_CNT_EN
    // -------------------------------------------------------------------------
    // Dropped-message counter (saturating)
    // -------------------------------------------------------------------------
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Count PUSH cycles that strobe no terminal, holding at all-ones
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (state_q == PUSH && push_vec == '0 && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
